// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared matrix multiplier widths and element types
package matmul_pkg;

    localparam int MM_DATA_W   = 32;
    localparam int MM_ELEM_W   = 8;
    localparam int MM_NUM_ELEM = MM_DATA_W / MM_ELEM_W;

    typedef logic [MM_ELEM_W-1:0]            mm_elem_t;
    typedef logic [$clog2(MM_NUM_ELEM)-1:0]  mm_idx_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through read
module sync_fifo
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    // A push on a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr];

    // Storage array; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level disambiguates full/empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/matmul_result_drain.sv
// rtl/matmul_result_drain.sv - buffers multiplier results and streams them as elements
module matmul_result_drain
    import matmul_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int ELEM_W = MM_ELEM_W,
    parameter int DEPTH  = 2
)
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  c_in,
    input  logic                               c_done,
    output logic                               can_accept,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [ELEM_W-1:0]                  m_data,
    output logic [$clog2(DATA_W/ELEM_W)-1:0]   m_index,
    output logic                               m_last,
    output logic                               overflow,
    input  logic                               clear_ovf,
    output logic [$clog2(DEPTH):0]             level
);

    localparam int NUM_ELEM = DATA_W / ELEM_W;
    localparam int IDX_W    = $clog2(NUM_ELEM);

    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [IDX_W-1:0]  idx;
    logic [ELEM_W-1:0] elem;

    assign m_valid = !empty;
    assign m_index = idx;
    assign m_last  = m_valid && (idx == IDX_W'(NUM_ELEM - 1));
    assign m_data  = m_valid ? elem : '0;

    // A word leaves only when its final element is accepted downstream.
    assign pop        = m_valid && m_ready && m_last;
    assign can_accept = !full || pop;
    assign push       = c_done && can_accept;
    assign drop       = c_done && !can_accept;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (c_in),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Select element idx of the head word, most significant element first.
    always_comb begin
        elem = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (idx == IDX_W'(k)) begin
                elem = head[DATA_W-1-k*ELEM_W -: ELEM_W];
            end
        end
    end

    // Element counter advances on every transfer and rewinds after the last element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (m_valid && m_ready) begin
            idx <= m_last ? '0 : idx + IDX_W'(1);
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matmul_result_drain.sv
// tb/tb_matmul_result_drain.sv - randomized and directed bench with reference model
module tb_matmul_result_drain;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] c_in;
    logic        c_done;
    logic        can_accept;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_index;
    logic        m_last;
    logic        overflow;
    logic        clear_ovf;
    logic [1:0]  level;

    matmul_result_drain #(.DATA_W(32), .ELEM_W(8), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .c_in       (c_in),
        .c_done     (c_done),
        .can_accept (can_accept),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .level      (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: queue of whole words, element position, sticky flag
    logic [31:0] mq[$];
    int          m_idx;
    bit          m_ovf;

    // DUT outputs captured in the most recent step
    logic        s_valid, s_last, s_ovf, s_ca;
    logic [7:0]  s_data;
    logic [1:0]  s_index, s_level;
    logic [7:0]  got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idx = 0;
        m_ovf = 0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input bit done, input logic [31:0] c, input bit rdy, input bit clr);
        bit          mv, ml, ca, xfer;
        logic [7:0]  md;
        @(negedge clk);
        c_done    = done;
        c_in      = c;
        m_ready   = rdy;
        clear_ovf = clr;
        #1;
        s_valid = m_valid; s_data = m_data; s_index = m_index; s_last = m_last;
        s_ovf = overflow; s_level = level; s_ca = can_accept;

        mv   = (mq.size() != 0);
        md   = mv ? 8'((mq[0] >> (24 - 8 * m_idx)) & 32'hFF) : 8'h00;
        ml   = mv && (m_idx == 3);
        xfer = mv && rdy;
        ca   = (mq.size() < DEPTH) || (xfer && ml);

        chk("m_valid",    32'(s_valid), 32'(mv));
        chk("m_data",     32'(s_data),  32'(md));
        chk("m_index",    32'(s_index), 32'(m_idx));
        chk("m_last",     32'(s_last),  32'(ml));
        chk("overflow",   32'(s_ovf),   32'(m_ovf));
        chk("level",      32'(s_level), 32'(mq.size()));
        chk("can_accept", 32'(s_ca),    32'(ca));

        if (xfer) begin
            got.push_back(s_data);
            if (ml) begin
                void'(mq.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (done && ca)        mq.push_back(c);
        if (done && !ca)       m_ovf = 1;
        else if (clr)          m_ovf = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        c_done = 0; clear_ovf = 0;
        #1;
        chk("rst m_valid",    32'(m_valid),    0);
        chk("rst m_data",     32'(m_data),     0);
        chk("rst m_index",    32'(m_index),    0);
        chk("rst m_last",     32'(m_last),     0);
        chk("rst overflow",   32'(overflow),   0);
        chk("rst level",      32'(level),      0);
        chk("rst can_accept", 32'(can_accept), 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] word_at(int base);
        return {got[base], got[base+1], got[base+2], got[base+3]};
    endfunction

    logic [7:0] exp_bytes [4];

    initial begin
        exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3; exp_bytes[3] = 8'hD4;
        reset = 1'b1; c_in = '0; c_done = 0; m_ready = 0; clear_ovf = 0;
        model_reset();
        do_reset();

        // single word with m_ready held high
        step(0, 0, 1, 0);
        step(1, 32'hA1B2C3D4, 1, 0);
        chk("single pre level", 32'(s_level), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0);
            chk("single data",  32'(s_data),  32'(exp_bytes[i]));
            chk("single index", 32'(s_index), 32'(i));
            chk("single last",  32'(s_last),  32'(i == 3));
            chk("single level", 32'(s_level), 1);
        end
        step(0, 0, 1, 0);
        chk("single drained valid", 32'(s_valid), 0);
        chk("single drained level", 32'(s_level), 0);

        // backpressure pattern 1,0,0,1,0,0,...
        step(1, 32'hA1B2C3D4, 0, 0);
        got.delete();
        for (int i = 0; i < 12; i++) step(0, 0, (i % 3) == 0, 0);
        chk("bp count", 32'(got.size()), 4);
        if (got.size() == 4) chk("bp word", word_at(0), 32'hA1B2C3D4);
        step(0, 0, 0, 0);
        chk("bp drained", 32'(s_valid), 0);

        // fill and overflow with m_ready low
        step(1, 32'h11111111, 0, 0);
        step(1, 32'h22222222, 0, 0);
        step(1, 32'h33333333, 0, 0);
        chk("fill level", 32'(s_level), 2);
        chk("fill can_accept", 32'(s_ca), 0);
        step(0, 0, 0, 0);
        chk("fill overflow", 32'(s_ovf), 1);
        got.delete();
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        chk("fill drain count", 32'(got.size()), 8);
        if (got.size() == 8) begin
            chk("fill word0", word_at(0), 32'h11111111);
            chk("fill word1", word_at(4), 32'h22222222);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("ovf cleared", 32'(s_ovf), 0);

        // full FIFO with simultaneous pop and push
        step(1, 32'h11111111, 0, 0);
        step(1, 32'h22222222, 0, 0);
        got.delete();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(1, 32'h44444444, 1, 0);
        chk("pp last", 32'(s_last), 1);
        chk("pp can_accept", 32'(s_ca), 1);
        chk("pp level before", 32'(s_level), 2);
        step(0, 0, 0, 0);
        chk("pp level after", 32'(s_level), 2);
        chk("pp overflow", 32'(s_ovf), 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        chk("pp count", 32'(got.size()), 12);
        if (got.size() == 12) chk("pp tail word", word_at(8), 32'h44444444);

        // overflow set beats clear
        step(1, 32'h11111111, 0, 0);
        step(1, 32'h22222222, 0, 0);
        step(1, 32'h33333333, 0, 1);
        step(0, 0, 0, 0);
        chk("prio ovf held", 32'(s_ovf), 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("prio ovf cleared", 32'(s_ovf), 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);

        // reset in the middle of a word
        step(1, 32'hA1B2C3D4, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("mid B2", 32'(s_data), 32'hB2);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("post reset valid", 32'(s_valid), 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        chk("final empty", 32'(s_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Reader for the matrix multiplier's packed result bus. Captures the 32-bit result word `C` on each `done` pulse into a small FIFO, then serializes each word as four 8-bit elements over a valid/ready stream toward the cluster interconnect. It exports backpressure (`can_accept`) so the sequencing controller gates the multiplier's `start`. Results that arrive while the buffer is full are dropped and flagged.

## Interface
- `DATA_W`, default 32: width of the captured result word.
- `ELEM_W`, default 8: element width; `NUM_ELEM = DATA_W/ELEM_W` (4). `DATA_W` must be an exact multiple of `ELEM_W`.
- `DEPTH`, default 2: FIFO depth in words; power of two, ≥2.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `c_in`, input, DATA_W: result word from the multiplier.
- `c_done`, input, 1: one-cycle pulse; `c_in` is valid in the same cycle.
- `can_accept`, output, 1: high when a push this cycle would be accepted.
- `m_valid`, output, 1: stream element valid.
- `m_ready`, input, 1: downstream ready.
- `m_data`, output, ELEM_W: current element.
- `m_index`, output, $clog2(NUM_ELEM): element index within the word (0..3).
- `m_last`, output, 1: high with element NUM_ELEM-1.
- `overflow`, output, 1: sticky; set when a `c_done` is dropped.
- `clear_ovf`, input, 1: synchronous clear of `overflow`.
- `level`, output, $clog2(DEPTH)+1: number of words held.

## Operation
- Push: `c_done && can_accept` writes `c_in` at the FIFO tail.
- `can_accept = !full || pop_this_cycle`, where `pop_this_cycle = m_valid && m_ready && m_last`. A push and a pop in the same cycle on a full FIFO are both accepted, and `level` is unchanged.
- Drop: `c_done && !can_accept` discards the word and sets `overflow` on the next edge.
- Serializer: an element counter `idx` runs 0..NUM_ELEM-1 over the head word.
  - Element k = `head[DATA_W-1-k*ELEM_W -: ELEM_W]`, MSB first. This matches the multiplier's packing, where `C[31:24]` is result 0.
- `m_valid = !empty`. `m_data`, `m_index = idx` and `m_last = (idx == NUM_ELEM-1)` are combinational from the head entry and `idx`.
- On each transfer (`m_valid && m_ready`):
  - not last: `idx` increments.
  - last: `idx` returns to 0 and the head is popped.
- Wrap-around: read and write pointers are modulo DEPTH. `level` is tracked explicitly, so full (`level == DEPTH`) and empty (`level == 0`) are unambiguous.
- `overflow`: a set and `clear_ovf` in the same cycle leaves it set (set wins).
- Reset mid-operation: FIFO emptied and `idx` = 0; any partially sent word is abandoned.

## Timing
- Reset values: `m_valid` 0, `m_data` 0, `m_index` 0, `m_last` 0, `overflow` 0, `level` 0, `can_accept` 1.
- Latency: `c_done` at edge N gives `m_valid` = 1 in the cycle after edge N (1 cycle).
- With `m_ready` held high, one word drains in NUM_ELEM cycles.
- Back-to-back words stream with no bubble: element 0 of the next word is presented in the cycle after the last element of the previous word.
- `m_data`, `m_index` and `m_last` stay stable while `m_valid && !m_ready`.
- `m_valid` never drops without a transfer, except on reset.
- `can_accept` is combinational from `level`, `m_valid`, `m_ready` and `m_last`. There is no path from `c_done` to `can_accept`.

## Structure
- Shared package `matmul_pkg`:
  - `MM_DATA_W` = 32 and `MM_ELEM_W` = 8.
  - `MM_NUM_ELEM`.
  - typedef `mm_elem_t` (logic [7:0]).
  - typedef `mm_idx_t` (logic [1:0]).
- The multiplier and its future operand loader use the same package.
- One sub-module: `sync_fifo` (params WIDTH, DEPTH; ports push, pop, wdata, rdata, full, empty, level), with a first-word-fall-through read.
- Serializer counter, overflow flag and `can_accept` logic live in the top.

## Test plan
- Single word: `c_in` = 0xA1B2C3D4, `c_done` pulse, `m_ready` = 1 → on consecutive cycles `m_data` = A1, B2, C3, D4; `m_index` = 0, 1, 2, 3; `m_last` only on D4; `level` goes 1→0.
- Backpressure: same word with `m_ready` toggling 1,0,0,1,… → each element held stable while stalled; no element duplicated or skipped.
- Fill and overflow, DEPTH = 2, `m_ready` = 0: push 0x11111111, 0x22222222, 0x33333333 → `level` = 2, `can_accept` = 0, third word dropped, `overflow` = 1; then drain yields only 11…/22….
- Full with simultaneous pop and push: FIFO full, `m_ready` = 1, `c_done` with 0x44444444 in the cycle `m_last` transfers → push accepted, `level` stays 2, `overflow` stays 0, 0x44444444 emitted last.
- Overflow clear priority: `clear_ovf` = 1 in the same cycle as a dropped `c_done` → `overflow` remains 1; a `clear_ovf` pulse on its own afterwards → `overflow` = 0.
- Reset mid-word: assert `reset` after element B2 of 0xA1B2C3D4 → all outputs at their reset values immediately; after release `m_valid` = 0 until the next `c_done`.
